// File: rtl/video_stream_gen.sv
// video_stream_gen: vs/de/data frame timing generator with selectable test patterns.
// Each line is VIDEO_PRE_WIDTH blanking clocks followed by VIDEO_WIDTH active pixels.
module video_stream_gen #(
    parameter int DSIZE            = 24,
    parameter int VIDEO_WIDTH      = 1920,
    parameter int VIDEO_PRE_WIDTH  = 280,
    parameter int VIDEO_HEIGHT     = 1080,
    parameter int VIDEO_PRE_HEIGHT = 45,
    parameter int VS_LINES         = 5
) (
    input  logic             clock,
    input  logic             rst,
    input  logic             enable,
    input  logic [1:0]       pattern_sel,
    output logic             outvs,
    output logic             outde,
    output logic [DSIZE-1:0] outdata,
    output logic             frame_start,
    output logic             busy
);
    localparam int H_TOT = VIDEO_PRE_WIDTH + VIDEO_WIDTH;
    localparam int V_TOT = VIDEO_PRE_HEIGHT + VIDEO_HEIGHT;
    localparam int HW    = $clog2(H_TOT);
    localparam int VW    = $clog2(V_TOT);
    localparam int BW    = VIDEO_WIDTH / 8;
    localparam int SW    = $clog2(BW);
    localparam int CW    = DSIZE / 3;

    typedef enum logic [1:0] {IDLE, RUN, STOP} state_t;

    state_t           state;
    logic [HW-1:0]    hcnt, x;
    logic [VW-1:0]    vcnt, y;
    logic [2:0]       bar, c;
    logic [SW-1:0]    seg;
    logic [DSIZE-1:0] frame_cnt, frame_val, bars, pix;
    logic [1:0]       frame_sel;
    logic             h_end, v_end, f_end, f_start, vs, de;

    assign h_end   = hcnt == HW'(H_TOT - 1);
    assign v_end   = vcnt == VW'(V_TOT - 1);
    assign f_end   = h_end && v_end;
    assign f_start = hcnt == '0 && vcnt == '0;
    assign vs      = vcnt < VW'(VS_LINES);
    assign de      = hcnt >= HW'(VIDEO_PRE_WIDTH) && vcnt >= VW'(VIDEO_PRE_HEIGHT);
    assign x       = hcnt - HW'(VIDEO_PRE_WIDTH);
    assign y       = vcnt - VW'(VIDEO_PRE_HEIGHT);
    assign c       = 3'd7 - bar;
    assign bars    = {{CW{c[2]}}, {CW{c[1]}}, {CW{c[0]}}};
    assign pix     = frame_sel == 2'd0 ? DSIZE'(x) + DSIZE'(y) :
                     frame_sel == 2'd1 ? bars :
                     frame_sel == 2'd2 ? {DSIZE{x[3] ^ y[3]}} : frame_val;

    always_ff @(posedge clock or posedge rst) begin
        if (rst) begin
            state       <= IDLE;
            hcnt        <= '0;
            vcnt        <= '0;
            bar         <= '0;
            seg         <= '0;
            frame_cnt   <= '0;
            frame_val   <= '0;
            frame_sel   <= '0;
            outvs       <= 1'b0;
            outde       <= 1'b0;
            outdata     <= '0;
            frame_start <= 1'b0;
            busy        <= 1'b0;
        end else begin
            busy <= state != IDLE;
            if (state == IDLE) begin
                state       <= enable ? RUN : IDLE;
                hcnt        <= '0;
                vcnt        <= '0;
                bar         <= '0;
                seg         <= '0;
                outvs       <= 1'b0;
                outde       <= 1'b0;
                outdata     <= '0;
                frame_start <= 1'b0;
            end else begin
                // RUN and STOP both let the frame finish; only the frame-end exit differs by enable
                state <= enable ? RUN : f_end ? IDLE : STOP;
                hcnt  <= h_end ? '0 : hcnt + 1'b1;
                if (h_end)
                    vcnt <= v_end ? '0 : vcnt + 1'b1;
                // bar/seg track the counter value they will sit beside next cycle
                if (hcnt == HW'(VIDEO_PRE_WIDTH - 1)) begin
                    bar <= '0;
                    seg <= '0;
                end else if (de) begin
                    seg <= seg == SW'(BW - 1) ? '0 : seg + 1'b1;
                    if (seg == SW'(BW - 1))
                        bar <= bar + 1'b1;
                end
                if (f_start) begin
                    frame_sel <= pattern_sel;
                    frame_val <= frame_cnt;
                end
                if (f_end)
                    frame_cnt <= frame_cnt + 1'b1;
                outvs       <= vs;
                outde       <= de;
                outdata     <= de ? pix : '0;
                frame_start <= f_start;
            end
        end
    end
endmodule
